// File: rtl/lwb_pkg.sv
// Shared definitions for the load writeback unit: funct3 codes, FSM state
// encoding, default widths and small decode helpers.
package lwb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lwb_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // Halfword loads need addr[0]==0; word loads need addr[1:0]==0.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LH, F3_LHU: return off[0];
            F3_LW:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a loaded word,
// driven by the RISC-V load funct3 and the byte offset within the word.
module load_extract
    import lwb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Load writeback unit: accepts one load, reads the data cache, writes the
// extended result to the register file. Build option LWB_MISALIGN_TRAP_EN.
module load_writeback_unit
    import lwb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [XLEN-1:0]   ld_addr,
    input  logic [2:0]        ld_funct3,
    input  logic [REG_AW-1:0] ld_rd,
    output logic              cache_req_valid,
    input  logic              cache_req_ready,
    output logic [XLEN-1:0]   cache_req_addr,
    input  logic              cache_rsp_valid,
    input  logic [XLEN-1:0]   cache_rsp_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd,
    output logic              stall,
    output logic              ld_err,
    output lwb_state_e        dbg_state
);

    // Handshakes: a transfer happens on a rising CLK edge where valid and ready
    // are both high; a raised valid holds, with its payload stable, until then.

    lwb_state_e        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              req_valid_q, req_valid_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_a3_q, rf_a3_d;
    logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
    logic              ld_err_q, ld_err_d;
    logic              misaligned;
    logic              bad_req;
    logic [XLEN-1:0]   ext_data;

`ifdef LWB_MISALIGN_TRAP_EN
    assign misaligned = f3_misaligned(ld_funct3, ld_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif
    assign bad_req = !f3_legal(ld_funct3) || misaligned;

    load_extract #(.XLEN(XLEN)) u_extract (
        .word   (cache_rsp_data),
        .funct3 (funct3_q),
        .off    (addr_q[1:0]),
        .result (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        rf_we_d  = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd_d  = rf_wd_q;
        ld_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    addr_d   = ld_addr;
                    funct3_d = ld_funct3;
                    rd_d     = ld_rd;
                    if (bad_req) ld_err_d = 1'b1;
                    else         state_d  = REQ;
                end
            end
            REQ: begin
                if (cache_req_ready) state_d = WAIT;
            end
            WAIT: begin
                // Miss latency is unbounded, so there is deliberately no timeout here.
                if (cache_rsp_valid) begin
                    state_d = WB;
                    rf_a3_d = rd_q;
                    rf_wd_d = ext_data;
                    rf_we_d = (rd_q != '0);
                end
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            req_valid_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_a3_q     <= '0;
            rf_wd_q     <= '0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            req_valid_q <= req_valid_d;
            rf_we_q     <= rf_we_d;
            rf_a3_q     <= rf_a3_d;
            rf_wd_q     <= rf_wd_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign stall           = (state_q != IDLE);
    assign ld_ready        = ~stall;
    assign cache_req_valid = req_valid_q;
    assign cache_req_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign rf_we           = rf_we_q;
    assign rf_a3           = rf_a3_q;
    assign rf_wd           = rf_wd_q;
    assign ld_err          = ld_err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: directed scenarios plus random
// loads checked against an arithmetic model of RISC-V load semantics.
module tb_load_writeback_unit;
    import lwb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [4:0]  ld_rd;
    logic        cache_req_valid;
    logic        cache_req_ready;
    logic [31:0] cache_req_addr;
    logic        cache_rsp_valid;
    logic [31:0] cache_rsp_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        stall;
    logic        ld_err;
    lwb_state_e  dbg_state;

    always #5 CLK = ~CLK;

    load_writeback_unit dut (
        .CLK(CLK), .RST(RST),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_funct3(ld_funct3), .ld_rd(ld_rd),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_addr(cache_req_addr), .cache_rsp_valid(cache_rsp_valid),
        .cache_rsp_data(cache_rsp_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .stall(stall), .ld_err(ld_err), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int err_cnt  = 0;
    int req_cnt  = 0;
    logic [31:0] exp_q[$];

    always @(negedge CLK) begin
        if (rf_we === 1'b1) we_cnt++;
        if (ld_err === 1'b1) err_cnt++;
        if (cache_req_valid === 1'b1) req_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: pick the addressed byte/half by shifting, then extend numerically.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [31:0] addr);
        longint unsigned w;
        longint v;
        w = word;
        case (f3)
            3'b000, 3'b100: begin
                v = longint'((w >> (8 * (addr % 4))) % 256);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = longint'((w >> (16 * ((addr / 2) % 2))) % 65536);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    function automatic bit model_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LWB_MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) return 1'b1;
        if (f3 == 3'b010 && addr[1:0] != 2'b00) return 1'b1;
`endif
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    // Drives one legal load; the sample after the response edge is the WB cycle.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] data, input int req_lat, input int rsp_lat,
                            output logic we, output logic [31:0] wd, output logic [4:0] a3,
                            output bit hs_ok, output logic [31:0] req_addr);
        hs_ok = (ld_ready === 1'b1) && (stall === 1'b0);
        ld_valid = 1'b1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
        tick();
        ld_valid = 1'b0; ld_addr = $urandom; ld_funct3 = 3'($urandom); ld_rd = 5'($urandom);
        req_addr = cache_req_addr;
        for (int i = 0; i < req_lat; i++) begin
            if (cache_req_valid !== 1'b1 || stall !== 1'b1 || ld_ready !== 1'b0 ||
                cache_req_addr !== req_addr) hs_ok = 1'b0;
            cache_rsp_valid = (i == 0);
            cache_rsp_data  = $urandom;
            tick();
        end
        cache_rsp_valid = 1'b0;
        if (cache_req_valid !== 1'b1 || cache_req_addr !== req_addr || stall !== 1'b1) hs_ok = 1'b0;
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        for (int i = 0; i < rsp_lat; i++) begin
            if (cache_req_valid !== 1'b0 || stall !== 1'b1 || rf_we !== 1'b0) hs_ok = 1'b0;
            tick();
        end
        cache_rsp_valid = 1'b1; cache_rsp_data = data;
        tick();
        cache_rsp_valid = 1'b0; cache_rsp_data = $urandom;
        we = rf_we; wd = rf_wd; a3 = rf_a3;
        if (stall !== 1'b1 || cache_req_valid !== 1'b0) hs_ok = 1'b0;
        tick();
        if (rf_we !== 1'b0 || stall !== 1'b0 || ld_ready !== 1'b1) hs_ok = 1'b0;
    endtask

    // Drives one load that must be rejected with an ld_err pulse.
    task automatic run_err_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                                output bit ok, output int err_d, output int req_d);
        int e0;
        int r0;
        e0 = err_cnt; r0 = req_cnt;
        ok = (ld_ready === 1'b1);
        ld_valid = 1'b1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
        tick();
        ld_valid = 1'b0;
        if (ld_err !== 1'b1 || ld_ready !== 1'b1 || stall !== 1'b0 || dbg_state !== IDLE) ok = 1'b0;
        tick();
        if (ld_err !== 1'b0 || cache_req_valid !== 1'b0) ok = 1'b0;
        tick();
        err_d = err_cnt - e0; req_d = req_cnt - r0;
    endtask

    task automatic test_reset();
        RST = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
        cache_req_ready = 1'b0; cache_rsp_valid = 1'b0; cache_rsp_data = '0;
        repeat (3) tick();
        n_checks++;
        if ({ld_ready, cache_req_valid, rf_we, stall, ld_err} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 10000", {ld_ready, cache_req_valid, rf_we, stall, ld_err});
        end
        RST = 1'b1;
        tick();
        n_checks++;
        if ({rf_a3, rf_wd} !== 37'd0) begin
            n_fail++; $display("FAIL reset_rf: got a3=%h wd=%h expected 0", rf_a3, rf_wd);
        end
        n_checks++;
        if (dbg_state !== IDLE || ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_state: got %0d ready=%b expected IDLE ready=1", dbg_state, ld_ready);
        end
    endtask

    task automatic test_lb();
        logic we; logic [31:0] wd; logic [4:0] a3; bit ok; logic [31:0] ra; int w0;
        w0 = we_cnt;
        run_load(32'h0000_0103, F3_LB, 5'd5, 32'h80FF_1234, 0, 0, we, wd, a3, ok, ra);
        n_checks++;
        if (we !== 1'b1) begin n_fail++; $display("FAIL lb_we_t3: got %b expected 1", we); end
        n_checks++;
        if (wd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wd: got %h expected ffffff80", wd); end
        n_checks++;
        if (a3 !== 5'd5) begin n_fail++; $display("FAIL lb_a3: got %0d expected 5", a3); end
        n_checks++;
        if (ra !== 32'h0000_0100) begin n_fail++; $display("FAIL lb_req_addr: got %h expected 00000100", ra); end
        n_checks++;
        if (!ok || we_cnt - w0 != 1) begin n_fail++; $display("FAIL lb_handshake: got ok=%b we_pulses=%0d expected 1/1", ok, we_cnt - w0); end
    endtask

    task automatic test_lhu_stall();
        logic we; logic [31:0] wd; logic [4:0] a3; bit ok; logic [31:0] ra; int w0;
        w0 = we_cnt;
        run_load(32'h0000_0202, F3_LHU, 5'd12, 32'hBEEF_0001, 4, 6, we, wd, a3, ok, ra);
        n_checks++;
        if (wd !== 32'h0000_BEEF || we !== 1'b1) begin n_fail++; $display("FAIL lhu_wd: got we=%b wd=%h expected 1 0000beef", we, wd); end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lhu_stall: got handshake/stall ok=%b expected 1", ok); end
        n_checks++;
        if (we_cnt - w0 != 1 || ra !== 32'h0000_0200) begin
            n_fail++; $display("FAIL lhu_one_we: got pulses=%0d addr=%h expected 1 00000200", we_cnt - w0, ra);
        end
    endtask

    task automatic test_lw_rd0();
        logic we; logic [31:0] wd; logic [4:0] a3; bit ok; logic [31:0] ra; int w0;
        w0 = we_cnt;
        run_load(32'h0000_0400, F3_LW, 5'd0, 32'hDEAD_BEEF, 1, 2, we, wd, a3, ok, ra);
        n_checks++;
        if (we !== 1'b0 || we_cnt - w0 != 0) begin n_fail++; $display("FAIL rd0_no_we: got we=%b pulses=%0d expected 0", we, we_cnt - w0); end
        n_checks++;
        if (!ok || dbg_state !== IDLE) begin n_fail++; $display("FAIL rd0_wb_idle: got ok=%b state=%0d expected 1 IDLE", ok, dbg_state); end
    endtask

    task automatic test_illegal();
        logic [2:0] bad_f3 [3];
        bit ok; int ed; int rd;
        bad_f3 = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            run_err_load(32'h0000_0500 + 32'(i), bad_f3[i], 5'd3, ok, ed, rd);
            n_checks++;
            if (!ok || ed != 1 || rd != 0) begin
                n_fail++; $display("FAIL illegal_f3_%b: got ok=%b err_pulses=%0d req_cycles=%0d expected 1 1 0", bad_f3[i], ok, ed, rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = we_cnt;
        ld_valid = 1'b1; ld_addr = 32'h0000_0300; ld_funct3 = F3_LW; ld_rd = 5'd7;
        tick();
        ld_valid = 1'b0; cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        n_checks++;
        if (dbg_state !== WAIT) begin n_fail++; $display("FAIL rstmid_wait: got %0d expected WAIT", dbg_state); end
        RST = 1'b0;
        #1;
        n_checks++;
        if ({cache_req_valid, rf_we, stall, ld_err, rf_a3, rf_wd} !== 41'd0 || ld_ready !== 1'b1 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL rstmid_outs: got req=%b we=%b stall=%b err=%b a3=%h wd=%h state=%0d expected all 0 IDLE",
                               cache_req_valid, rf_we, stall, ld_err, rf_a3, rf_wd, dbg_state);
        end
        tick();
        RST = 1'b1;
        tick();
        cache_rsp_valid = 1'b1; cache_rsp_data = 32'hCAFE_F00D;
        tick();
        cache_rsp_valid = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (we_cnt != w0 || dbg_state !== IDLE || rf_wd !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_late_rsp: got pulses=%0d state=%0d wd=%h expected 0 IDLE 0", we_cnt - w0, dbg_state, rf_wd);
        end
    endtask

    task automatic test_misalign();
`ifdef LWB_MISALIGN_TRAP_EN
        bit ok; int ed; int rd; int w0;
        w0 = we_cnt;
        run_err_load(32'h0000_0101, F3_LW, 5'd9, ok, ed, rd);
        n_checks++;
        if (!ok || ed != 1 || rd != 0 || we_cnt != w0) begin
            n_fail++; $display("FAIL misalign_trap: got ok=%b err=%0d req=%0d we=%0d expected 1 1 0 0", ok, ed, rd, we_cnt - w0);
        end
`else
        logic we; logic [31:0] wd; logic [4:0] a3; bit ok; logic [31:0] ra;
        run_load(32'h0000_0101, F3_LW, 5'd9, 32'h1234_5678, 0, 1, we, wd, a3, ok, ra);
        n_checks++;
        if (ra !== 32'h0000_0100 || we !== 1'b1 || wd !== 32'h1234_5678 || !ok) begin
            n_fail++; $display("FAIL misalign_ignored: got addr=%h we=%b wd=%h ok=%b expected 00000100 1 12345678 1", ra, we, wd, ok);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic we; logic [31:0] wd; logic [4:0] a3; bit ok; logic [31:0] ra;
        run_load(32'h0000_0600, F3_LH, 5'd1, 32'h0000_8001, 0, 0, we, wd, a3, ok, ra);
        n_checks++;
        if (wd !== 32'hFFFF_8001 || !ok) begin n_fail++; $display("FAIL b2b_first: got wd=%h ok=%b expected ffff8001 1", wd, ok); end
        run_load(32'h0000_0607, F3_LBU, 5'd2, 32'hA5FF_FFFF, 0, 0, we, wd, a3, ok, ra);
        n_checks++;
        if (we !== 1'b1 || wd !== 32'h0000_00A5 || a3 !== 5'd2 || !ok) begin
            n_fail++; $display("FAIL b2b_second: got we=%b wd=%h a3=%0d ok=%b expected 1 000000a5 2 1", we, wd, a3, ok);
        end
    endtask

    task automatic test_random();
        logic [2:0] legal_f3 [5];
        logic we; logic [31:0] wd; logic [4:0] a3; bit ok; logic [31:0] ra;
        logic [31:0] addr; logic [31:0] data; logic [31:0] exp_wd; logic [2:0] f3; logic [4:0] rd;
        int ed; int rq;
        legal_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        for (int n = 0; n < 30; n++) begin
            addr = $urandom; data = $urandom;
            f3 = legal_f3[$urandom_range(0, 4)];
            rd = 5'($urandom_range(0, 31));
            if (model_trap(f3, addr)) begin
                run_err_load(addr, f3, rd, ok, ed, rq);
                n_checks++;
                if (!ok || ed != 1 || rq != 0) begin
                    n_fail++; $display("FAIL rand_trap_%0d: got ok=%b err=%0d req=%0d expected 1 1 0", n, ok, ed, rq);
                end
            end else begin
                exp_q.push_back(model_load(data, f3, addr));
                run_load(addr, f3, rd, data, $urandom_range(0, 3), $urandom_range(0, 4), we, wd, a3, ok, ra);
                exp_wd = exp_q.pop_front();
                n_checks++;
                if (we !== (rd != 5'd0) || !ok || ra !== {addr[31:2], 2'b00}) begin
                    n_fail++; $display("FAIL rand_ctl_%0d: got we=%b ok=%b addr=%h expected we=%b ok=1 addr=%h",
                                       n, we, ok, ra, rd != 5'd0, {addr[31:2], 2'b00});
                end
                if (rd != 5'd0) begin
                    n_checks++;
                    if (wd !== exp_wd || a3 !== rd) begin
                        n_fail++; $display("FAIL rand_data_%0d: f3=%b addr=%h got wd=%h a3=%0d expected %h %0d",
                                           n, f3, addr, wd, a3, exp_wd, rd);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_stall();
        test_lw_rd0();
        test_illegal();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
